led_pwm_array: RTL

Multi-channel LED driver for the Tiny Tapeout user tile; the parametrised successor to the single free-running-counter blinker. It holds one shared prescaler and one shared PWM counter. Each of `CHANNELS` outputs is independently configured through a one-cycle write port as off, static PWM, blink or breathe. It sits between the tile's input pins (configuration) and the LED output pins.

---
 rtl/led_pwm_array.sv | 125 ++++++++++++
 1 files changed

// File: rtl/led_pwm_array.sv
// Multi-channel LED driver: one shared prescaler and PWM counter feed per-channel
// off / PWM / blink / breathe generators with registered outputs.
module led_pwm_array #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 24,
  parameter int PWM_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_W-1:0]    wr_duty,
  output logic [CHANNELS-1:0] led_out,
  output logic                tick_out
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_PWM     = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam logic [PWM_W-1:0] LVL_MAX = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] LVL_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [PWM_W-1:0]    pwm_q, pwm_d;
  logic                phase_q, phase_d;
  logic                tick;
  mode_e               mode_q  [CHANNELS];
  mode_e               mode_d  [CHANNELS];
  logic [PWM_W-1:0]    duty_q  [CHANNELS];
  logic [PWM_W-1:0]    duty_d  [CHANNELS];
  logic [PWM_W-1:0]    level_q [CHANNELS];
  logic [PWM_W-1:0]    level_d [CHANNELS];
  logic                dir_q   [CHANNELS];
  logic                dir_d   [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;
  logic                tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      phase_q <= 1'b0;
      led_q   <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= MODE_OFF;
        duty_q[i]  <= '0;
        level_q[i] <= '0;
        dir_q[i]   <= 1'b0;
      end
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      tick_q  <= tick;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= mode_d[i];
        duty_q[i]  <= duty_d[i];
        level_q[i] <= level_d[i];
        dir_q[i]   <= dir_d[i];
      end
    end
  end

  // Breathe stepping first, then the write override so a same-edge write wins.
  always_comb begin
    tick    = &presc_q;
    presc_d = presc_q + 1'b1;
    pwm_d   = pwm_q + 1'b1;
    phase_d = phase_q ^ tick;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]  = mode_q[i];
      duty_d[i]  = duty_q[i];
      level_d[i] = level_q[i];
      dir_d[i]   = dir_q[i];
      if (tick && mode_q[i] == MODE_BREATHE) begin
        if (!dir_q[i]) begin
          if (level_q[i] == LVL_MAX) begin
            dir_d[i]   = 1'b1;
            level_d[i] = LVL_MAX - 1'b1;
          end else begin
            level_d[i] = level_q[i] + 1'b1;
          end
        end else begin
          if (level_q[i] == '0) begin
            dir_d[i]   = 1'b0;
            level_d[i] = LVL_ONE;
          end else begin
            level_d[i] = level_q[i] - 1'b1;
          end
        end
      end
      // Indices at or above CHANNELS match no loop iteration, so they are dropped.
      if (wr_en && wr_ch == CH_W'(i)) begin
        mode_d[i]  = mode_e'(wr_mode);
        duty_d[i]  = wr_duty;
        level_d[i] = '0;
        dir_d[i]   = 1'b0;
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_q[i])
        MODE_PWM:     led_d[i] = (pwm_q < duty_q[i]);
        MODE_BLINK:   led_d[i] = phase_q;
        MODE_BREATHE: led_d[i] = (pwm_q < level_q[i]);
        default:      led_d[i] = 1'b0;
      endcase
    end
  end

  assign led_out  = led_q;
  assign tick_out = tick_q;

endmodule
